// File: rtl/chunked_addsub.sv
// Multi-cycle two's complement adder/subtractor: one CHUNK-bit slice per clock,
// LSB slice first, with a registered slice carry and ZF/SF/OF/CF flags on completion.
module chunked_addsub #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       cc
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CW     = $clog2(NCHUNK + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       cc_q, cc_d;
    logic             carry_q, carry_d;
    logic             zf_q, zf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CHUNK-1:0] slice_a, slice_b;
    logic [CHUNK:0]   slice_sum;
    logic             last_slice;
    logic             carry_into_msb;

    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int unsigned i = 0; i < NCHUNK; i++) begin
            if (cnt_q == CW'(i)) begin
                slice_a = a_q[i*CHUNK +: CHUNK];
                slice_b = b_q[i*CHUNK +: CHUNK];
            end
        end
        slice_sum      = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, carry_q};
        last_slice     = (cnt_q == CW'(NCHUNK - 1));
        // Carry into the MSB is recovered from the MSB's own sum bit.
        carry_into_msb = slice_a[CHUNK-1] ^ slice_b[CHUNK-1] ^ slice_sum[CHUNK-1];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        result_d = result_q;
        cc_d     = cc_q;
        carry_d  = carry_q;
        zf_d     = zf_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    a_d     = a;
                    b_d     = op ? ~b : b;
                    carry_d = op;
                    cnt_d   = '0;
                    sum_d   = '0;
                    zf_d    = 1'b1;
                end
            end
            RUN: begin
                for (int unsigned i = 0; i < NCHUNK; i++) begin
                    if (cnt_q == CW'(i)) begin
                        sum_d[i*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
                    end
                end
                carry_d = slice_sum[CHUNK];
                zf_d    = zf_q & (slice_sum[CHUNK-1:0] == '0);
                cnt_d   = cnt_q + CW'(1);
                if (last_slice) begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = sum_d;
                    cc_d     = {slice_sum[CHUNK],
                                carry_into_msb ^ slice_sum[CHUNK],
                                slice_sum[CHUNK-1],
                                zf_d};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            result_q <= '0;
            cc_q     <= '0;
            carry_q  <= 1'b0;
            zf_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            result_q <= result_d;
            cc_q     <= cc_d;
            carry_q  <= carry_d;
            zf_q     <= zf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cc     = cc_q;

endmodule

// File: tb/tb_chunked_addsub.sv
// Scoreboard bench for chunked_addsub: 64/16 and 8/8 instances, directed vectors,
// expected results queued at issue time and checked by per-instance done monitors.
module tb_chunked_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start64, op64, busy64, done64;
    logic [63:0] a64, b64, res64;
    logic [3:0]  cc64;
    logic        start8, op8, busy8, done8;
    logic [7:0]  a8, b8, res8;
    logic [3:0]  cc8;

    chunked_addsub #(.WIDTH(64), .CHUNK(16)) u64 (
        .clk(clk), .rst_n(rst_n), .start(start64), .op(op64), .a(a64), .b(b64),
        .busy(busy64), .done(done64), .result(res64), .cc(cc64)
    );

    chunked_addsub #(.WIDTH(8), .CHUNK(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(res8), .cc(cc8)
    );

    typedef struct packed {
        logic [63:0] res;
        logic [3:0]  cc;
    } exp_t;

    exp_t q64[$];
    exp_t q8[$];
    exp_t e64, e8;
    int   errors = 0;
    int   checks = 0;
    int   pushed64 = 0, seen64 = 0, pushed8 = 0, seen8 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done64 === 1'b1) begin
            seen64++;
            if (q64.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done64_unexpected: got done=1 expected no pending op");
            end else begin
                e64 = q64.pop_front();
                check("result64", res64, e64.res);
                check("cc64", 64'(cc64), 64'(e64.cc));
            end
        end
    end

    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            seen8++;
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done8_unexpected: got done=1 expected no pending op");
            end else begin
                e8 = q8.pop_front();
                check("result8", 64'(res8), e8.res);
                check("cc8", 64'(cc8), 64'(e8.cc));
            end
        end
    end

    task automatic wait_done64(input string name, input int exp_lat);
        int lat = 0;
        while (done64 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check(name, 64'(lat), 64'(exp_lat));
    endtask

    task automatic run64(input string name, input logic o, input logic [63:0] aa,
                         input logic [63:0] bb, input logic [63:0] er, input logic [3:0] ec);
        @(negedge clk);
        start64 = 1'b1;
        op64    = o;
        a64     = aa;
        b64     = bb;
        q64.push_back('{res: er, cc: ec});
        pushed64++;
        @(negedge clk);
        start64 = 1'b0;
        check({name, "_busy"}, 64'(busy64), 64'd1);
        wait_done64({name, "_latency"}, 4);
    endtask

    initial begin
        rst_n   = 1'b0;
        start64 = 1'b0; op64 = 1'b0; a64 = '0; b64 = '0;
        start8  = 1'b0; op8  = 1'b0; a8  = '0; b8  = '0;
        #1;
        check("rst_busy64", 64'(busy64), 64'd0);
        check("rst_done64", 64'(done64), 64'd0);
        check("rst_result64", res64, 64'd0);
        check("rst_cc64", 64'(cc64), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run64("add_wrap",  1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 4'b1001);
        run64("add_ovf",   1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b0110);
        run64("add_mix",   1'b0, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111,
              64'h1234_5678_9ABC_DF00, 4'b0000);
        run64("add_chain", 1'b0, 64'h0000_0000_0000_FFFF, 64'd1, 64'h0000_0000_0001_0000, 4'b0000);
        run64("sub_ovf",   1'b1, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b1100);
        run64("sub_neg",   1'b1, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0010);
        run64("sub_pos",   1'b1, 64'd7, 64'd5, 64'd2, 4'b1000);

        // Operands, op and a second start all change mid-run; only the first op counts.
        @(negedge clk);
        start64 = 1'b1; op64 = 1'b0; a64 = 64'h10; b64 = 64'h20;
        q64.push_back('{res: 64'h30, cc: 4'b0000});
        pushed64++;
        @(negedge clk);
        start64 = 1'b0; op64 = 1'b1; a64 = '1; b64 = 64'h5;
        @(negedge clk);
        check("hold_result64", res64, 64'd2);
        check("hold_cc64", 64'(cc64), 64'(4'b1000));
        start64 = 1'b1; b64 = 64'h1234;
        @(negedge clk);
        start64 = 1'b0; a64 = 64'h99;
        wait_done64("ignore_latency", 2);
        repeat (6) @(negedge clk);

        // Abort mid-run with reset: outputs clear without a clock and no done follows.
        @(negedge clk);
        start64 = 1'b1; op64 = 1'b0; a64 = 64'd1; b64 = 64'd1;
        @(negedge clk);
        start64 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy64", 64'(busy64), 64'd0);
        check("abort_done64", 64'(done64), 64'd0);
        check("abort_result64", res64, 64'd0);
        check("abort_cc64", 64'(cc64), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("abort_no_done", 64'(seen64), 64'(pushed64));

        run64("post_reset", 1'b0, 64'd3, 64'd4, 64'd7, 4'b0000);

        // Single-chunk instance with a back-to-back start on the done cycle.
        @(negedge clk);
        start8 = 1'b1; op8 = 1'b0; a8 = 8'h80; b8 = 8'h80;
        q8.push_back('{res: 64'h00, cc: 4'b1101});
        pushed8++;
        @(negedge clk);
        start8 = 1'b0;
        check("b2b_busy8_first", 64'(busy8), 64'd1);
        check("b2b_done8_early", 64'(done8), 64'd0);
        @(negedge clk);
        check("b2b_done8_first", 64'(done8), 64'd1);
        start8 = 1'b1; op8 = 1'b1; a8 = 8'h10; b8 = 8'h20;
        q8.push_back('{res: 64'hF0, cc: 4'b0010});
        pushed8++;
        @(negedge clk);
        start8 = 1'b0;
        check("b2b_busy8_second", 64'(busy8), 64'd1);
        @(negedge clk);
        check("b2b_done8_second", 64'(done8), 64'd1);
        repeat (4) @(negedge clk);

        check("done_count64", 64'(seen64), 64'(pushed64));
        check("done_count8", 64'(seen8), 64'(pushed8));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
